// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog register front end: register map,
// STATUS/CTRL bit positions and the bus handshake state type.
package wdt_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_KICK   = 8'h04;
    localparam logic [7:0] ADDR_TOCNT  = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;

    localparam int CTRL_WDEN_BIT     = 0;
    localparam int KICK_GO_BIT       = 0;
    localparam int ST_WTO_SYNC_BIT   = 0;
    localparam int ST_LIVE_BUSY_BIT  = 1;
    localparam int ST_TO_FLAG_BIT    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } wdt_if_state_e;

    // Build the STATUS read word from its three live bits.
    function automatic logic [31:0] status_word(input logic wto_sync,
                                                input logic live_busy,
                                                input logic to_flag);
        logic [31:0] w;
        w = '0;
        w[ST_WTO_SYNC_BIT]  = wto_sync;
        w[ST_LIVE_BUSY_BIT] = live_busy;
        w[ST_TO_FLAG_BIT]   = to_flag;
        return w;
    endfunction

endpackage

// File: rtl/wdt_reg_if_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module wdt_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/wdt_reg_if.sv
// Bus register front end for the watchdog: CTRL/KICK/TOCNT/STATUS registers,
// kick stretching toward the WDT domain and timeout flag/interrupt reporting.
module wdt_reg_if
    import wdt_pkg::*;
#(
    parameter int          LIVE_HOLD = 8,
    parameter logic [31:0] RST_TOCNT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        wdt_irq
);

    localparam logic [7:0] LIVE_HOLD_8 = 8'(LIVE_HOLD);

    wdt_if_state_e state_reg, state_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          err_reg, err_next;
    logic          wden_reg, wden_next;
    logic [31:0]   tocnt_reg, tocnt_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic          wdlive_reg, wdlive_next;
    logic          to_flag_reg, to_flag_next;
    logic          wto_sync;
    logic          wto_sync_d_reg;

    logic [7:0]    word_addr;
    logic          accept;
    logic          wr_ctrl, wr_kick, wr_tocnt, wr_clr;
    logic          dec_err;
    logic [31:0]   dec_rdata;
    logic          wto_rise;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    wdt_sync2 u_wto_sync (
        .clk (clk),
        .rst (rst),
        .d   (WTO),
        .q   (wto_sync)
    );

    assign word_addr = {req_addr[7:2], 2'b00};
    assign accept    = (state_reg == IDLE) && req_valid;
    assign wto_rise  = wto_sync && !wto_sync_d_reg;

    // Address decode: selects the register effect and the response payload.
    always_comb begin
        wr_ctrl   = 1'b0;
        wr_kick   = 1'b0;
        wr_tocnt  = 1'b0;
        wr_clr    = 1'b0;
        dec_err   = 1'b0;
        dec_rdata = '0;
        case (word_addr)
            ADDR_CTRL: begin
                if (req_write) wr_ctrl = 1'b1;
                else           dec_rdata[CTRL_WDEN_BIT] = wden_reg;
            end
            ADDR_KICK: begin
                if (req_write) wr_kick = req_wdata[KICK_GO_BIT];
            end
            ADDR_TOCNT: begin
                if (req_write) begin
                    if (wden_reg) dec_err  = 1'b1;
                    else          wr_tocnt = 1'b1;
                end else begin
                    dec_rdata = tocnt_reg;
                end
            end
            ADDR_STATUS: begin
                if (req_write) begin
                    if (req_wdata[ST_TO_FLAG_BIT]) wr_clr  = 1'b1;
                    else                           dec_err = 1'b1;
                end else begin
                    dec_rdata = status_word(wto_sync, cnt_reg != 8'd0, to_flag_reg);
                end
            end
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = RESP;
                    rdata_next = dec_err ? 32'd0 : dec_rdata;
                    err_next   = dec_err;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wden_next  = wden_reg;
        tocnt_next = tocnt_reg;
        if (accept && wr_ctrl)  wden_next  = req_wdata[CTRL_WDEN_BIT];
        if (accept && wr_tocnt) tocnt_next = req_wdata;
    end

    // Disabling the watchdog kills any kick in flight; a kick while
    // disabled is silently ignored; a kick while busy simply reloads.
    always_comb begin
        cnt_next = cnt_reg;
        if (accept && wr_ctrl && !req_wdata[CTRL_WDEN_BIT]) begin
            cnt_next = 8'd0;
        end else if (accept && wr_kick && wden_reg) begin
            cnt_next = LIVE_HOLD_8;
        end else if (cnt_reg != 8'd0) begin
            cnt_next = cnt_reg - 8'd1;
        end
        wdlive_next = (cnt_next != 8'd0);
    end

    // A new timeout edge takes priority over a simultaneous W1C clear.
    always_comb begin
        to_flag_next = to_flag_reg;
        if (wto_rise)               to_flag_next = 1'b1;
        else if (accept && wr_clr)  to_flag_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            wden_reg       <= 1'b0;
            tocnt_reg      <= RST_TOCNT;
            cnt_reg        <= 8'd0;
            wdlive_reg     <= 1'b0;
            to_flag_reg    <= 1'b0;
            wto_sync_d_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            wden_reg       <= wden_next;
            tocnt_reg      <= tocnt_next;
            cnt_reg        <= cnt_next;
            wdlive_reg     <= wdlive_next;
            to_flag_reg    <= to_flag_next;
            wto_sync_d_reg <= wto_sync;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign WDEN       = wden_reg;
    assign WDLIVE     = wdlive_reg;
    assign WTOCNT     = tocnt_reg;
    assign wdt_irq    = to_flag_reg;

endmodule

// File: tb/tb_wdt_reg_if.sv
// Directed bench for wdt_reg_if: expected responses go into a scoreboard queue,
// a monitor pops and compares them as the DUT hands responses back.
module tb_wdt_reg_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        WDEN;
    logic        WDLIVE;
    logic [31:0] WTOCNT;
    logic        WTO = 1'b0;
    logic        wdt_irq;

    wdt_reg_if #(.LIVE_HOLD(8), .RST_TOCNT(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .WDEN       (WDEN),
        .WDLIVE     (WDLIVE),
        .WTOCNT     (WTOCNT),
        .WTO        (WTO),
        .wdt_irq    (wdt_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   live_hi = 0;
    int   live_rises = 0;
    logic live_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (WDLIVE) live_hi <= live_hi + 1;
        if (WDLIVE && !live_prev) live_rises <= live_rises + 1;
        live_prev <= WDLIVE;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    // Monitor: every consumed response is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got rdata=0x%08h err=%0b expected none",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int start_at);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc < start_at - 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        sb_q.push_back(exp_t'({exp_rd, exp_err}));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 (addr 0x%02h)", addr);
        end
        @(posedge clk);
        #1;
        last_acc  = cyc;
        req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(resp_valid && resp_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!(resp_valid && resp_ready)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: got resp_valid=%0b expected 1 (addr 0x%02h)", resp_valid, addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base_hi;
        int base_rise;
        int t0;
        int x;
        logic [31:0] held;

        // Reset state
        #12;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_wden", {31'd0, WDEN}, 32'd0);
        check("rst_wdlive", {31'd0, WDLIVE}, 32'd0);
        check("rst_wtocnt", WTOCNT, 32'hFFFF_FFFF);
        check("rst_irq", {31'd0, wdt_irq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Reset asserted in the middle of a RESP phase
        do_req(1'b1, 8'h08, 32'h0000_1234, 32'd0, 1'b0, 0);
        check("tocnt_pre_rst", WTOCNT, 32'h0000_1234);
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h00;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_resp_valid", {31'd0, resp_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_wtocnt", WTOCNT, 32'hFFFF_FFFF);
        check("midrst_wden", {31'd0, WDEN}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        resp_ready = 1'b1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);

        // TOCNT programming and lock while enabled
        do_req(1'b1, 8'h08, 32'h0000_0100, 32'd0, 1'b0, 0);
        check("wtocnt_100", WTOCNT, 32'h0000_0100);
        do_req(1'b1, 8'h00, 32'h0000_0001, 32'd0, 1'b0, 0);
        check("wden_on", {31'd0, WDEN}, 32'd1);
        do_req(1'b0, 8'h08, 32'd0, 32'h0000_0100, 1'b0, 0);
        do_req(1'b0, 8'h00, 32'd0, 32'h0000_0001, 1'b0, 0);
        do_req(1'b1, 8'h0B, 32'h0000_0055, 32'd0, 1'b1, 0);
        check("wtocnt_locked", WTOCNT, 32'h0000_0100);

        // Single kick: WDLIVE high for exactly LIVE_HOLD cycles
        base_hi = live_hi;
        base_rise = live_rises;
        do_req(1'b1, 8'h04, 32'h0000_0001, 32'd0, 1'b0, 0);
        repeat (15) @(negedge clk);
        check("kick_hi_cycles", live_hi - base_hi, 32'd8);
        check("kick_rises", live_rises - base_rise, 32'd1);

        // Re-kick 5 cycles after the first: 13 cycles, one continuous pulse
        base_hi = live_hi;
        base_rise = live_rises;
        do_req(1'b1, 8'h04, 32'h0000_0001, 32'd0, 1'b0, 0);
        t0 = last_acc;
        do_req(1'b1, 8'h04, 32'h0000_0001, 32'd0, 1'b0, t0 + 5);
        check("rekick_cycle", last_acc - t0, 32'd5);
        do_req(1'b0, 8'h0C, 32'd0, 32'h0000_0002, 1'b0, 0);
        repeat (20) @(negedge clk);
        check("rekick_hi_cycles", live_hi - base_hi, 32'd13);
        check("rekick_rises", live_rises - base_rise, 32'd1);

        // Disabling mid-kick drops WDLIVE; kicks while disabled do nothing
        base_hi = live_hi;
        do_req(1'b1, 8'h04, 32'h0000_0001, 32'd0, 1'b0, 0);
        do_req(1'b1, 8'h00, 32'h0000_0000, 32'd0, 1'b0, 0);
        check("disable_wdlive", {31'd0, WDLIVE}, 32'd0);
        check("disable_hi_cycles", live_hi - base_hi, 32'd2);
        do_req(1'b1, 8'h04, 32'h0000_0001, 32'd0, 1'b0, 0);
        repeat (10) @(negedge clk);
        check("kick_off_hi_cycles", live_hi - base_hi, 32'd2);
        do_req(1'b0, 8'h0C, 32'd0, 32'h0000_0000, 1'b0, 0);

        // WTO pulse through the synchronizer into TO_FLAG
        @(negedge clk);
        WTO = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("wto_irq_2edges", {31'd0, wdt_irq}, 32'd0);
        @(negedge clk);
        WTO = 1'b0;
        check("wto_irq_3edges", {31'd0, wdt_irq}, 32'd1);
        repeat (5) @(negedge clk);
        do_req(1'b0, 8'h0C, 32'd0, 32'h0000_0004, 1'b0, 0);
        do_req(1'b1, 8'h0C, 32'h0000_0004, 32'd0, 1'b0, 0);
        check("w1c_irq", {31'd0, wdt_irq}, 32'd0);

        // Clear on the same edge as a new rise: the set wins
        x = cyc + 10;
        fork
            do_req(1'b1, 8'h0C, 32'h0000_0004, 32'd0, 1'b0, x);
            begin
                while (cyc < x - 3) @(negedge clk);
                WTO = 1'b1;
                repeat (3) @(negedge clk);
                WTO = 1'b0;
            end
        join
        check("setwins_acc_cycle", last_acc, x);
        check("setwins_irq", {31'd0, wdt_irq}, 32'd1);

        // Error responses leave state untouched
        repeat (4) @(negedge clk);
        do_req(1'b0, 8'h10, 32'd0, 32'd0, 1'b1, 0);
        do_req(1'b1, 8'h0C, 32'h0000_0001, 32'd0, 1'b1, 0);
        check("err_irq_kept", {31'd0, wdt_irq}, 32'd1);
        do_req(1'b1, 8'h10, 32'h0000_0001, 32'd0, 1'b1, 0);
        check("err_wden_kept", {31'd0, WDEN}, 32'd0);
        do_req(1'b0, 8'h04, 32'd0, 32'd0, 1'b0, 0);
        do_req(1'b0, 8'h0C, 32'd0, 32'h0000_0004, 1'b0, 0);
        do_req(1'b1, 8'h0C, 32'h0000_0004, 32'd0, 1'b0, 0);
        check("err_clr_irq", {31'd0, wdt_irq}, 32'd0);

        // Response back-pressure: held stable, no new request taken
        resp_ready = 1'b0;
        @(negedge clk);
        sb_q.push_back(exp_t'({32'h0000_0100, 1'b0}));
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h08;
        @(posedge clk);
        #1;
        req_write = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 32'h0000_0001;
        held = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_rdata", resp_rdata, 32'h0000_0100);
        end
        check("stall_rdata_held", resp_rdata, held);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_wden_kept", {31'd0, WDEN}, 32'd0);
        check("stall_req_ready_after", {31'd0, req_ready}, 32'd1);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
